mem_stage_hs: RTL and testbench

Memory stage of the mips_16 pipeline with a request/acknowledge data-memory port. It sits between the EX→MEM and MEM→WB pipeline registers and accepts the 38-bit execute result word. Loads and stores are issued to a variable-latency data memory, and upstream stages are stalled until the access completes or a watchdog times out. The registered 37-bit write-back word and a hazard-detection destination are produced on the output side.

---
 rtl/mem_stage_hs.sv | 145 ++++++++++++++
 tb/tb_mem_stage_hs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// mips_16 memory stage with a request/acknowledge data-memory port.
// Loads and stores hold the stage until dmem_ack or a watchdog abort; ALU ops pass straight through.
module mem_stage_hs #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] pipeline_reg_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [36:0] pipeline_reg_out,
    output logic        out_valid,
    output logic [2:0]  mem_op_dest,
    output logic        timeout_err
);

    localparam logic [15:0] WAIT_LIMIT = 16'(ACK_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state, state_d;
    logic [37:0] hold;
    logic [15:0] wait_cnt;

    logic        in_is_mem;
    logic        hold_is_load;
    logic        accept_alu;
    logic        accept_mem;
    logic        complete;
    logic        abort;
    logic [36:0] result_d;
    logic        out_valid_d;

    // A store wins over the load flag when both are set; bit[0] still travels with the word.
    assign in_is_mem    = pipeline_reg_in[21] | pipeline_reg_in[0];
    assign hold_is_load = ~hold[21] & hold[0];

    assign in_ready   = (state == IDLE);
    assign dmem_we    = hold[21];
    assign dmem_addr  = hold[37:22];
    assign dmem_wdata = hold[20:5];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state;
        accept_alu = 1'b0;
        accept_mem = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_mem) begin
                        accept_mem = 1'b1;
                        state_d    = WAIT;
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ack is checked first so it wins over an expiring watchdog.
                if (dmem_req && dmem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d    = '0;
        out_valid_d = 1'b0;
        if (accept_alu) begin
            result_d    = {pipeline_reg_in[37:22], 16'h0000, pipeline_reg_in[4:0]};
            out_valid_d = 1'b1;
        end else if (complete) begin
            result_d    = {hold[37:22], hold_is_load ? dmem_rdata : 16'h0000, hold[4:0]};
            out_valid_d = 1'b1;
        end else if (abort) begin
            result_d    = {hold[37:22], 16'h0000, 1'b0, hold[3:0]};
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            hold             <= '0;
            dmem_req         <= 1'b0;
            wait_cnt         <= '0;
            pipeline_reg_out <= '0;
            out_valid        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            pipeline_reg_out <= result_d;
            out_valid        <= out_valid_d;
            if (accept_mem) begin
                hold     <= pipeline_reg_in;
                dmem_req <= 1'b1;
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (complete || abort) begin
                dmem_req <= 1'b0;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Hazard destination follows whichever stage currently owns the instruction.
    always_comb begin
        mem_op_dest = 3'd0;
        if (state == WAIT) begin
            if (hold[4]) mem_op_dest = hold[3:1];
        end else begin
            if (pipeline_reg_out[4]) mem_op_dest = pipeline_reg_out[3:1];
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs with a short watchdog (ACK_TIMEOUT=8).
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_mem_stage_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [37:0] pipeline_reg_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic [36:0] pipeline_reg_out;
    logic        out_valid;
    logic [2:0]  mem_op_dest;
    logic        timeout_err;

    int n_vec  = 0;
    int n_miss = 0;

    mem_stage_hs #(.ACK_TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_reg_in  (pipeline_reg_in),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .pipeline_reg_out (pipeline_reg_out),
        .out_valid        (out_valid),
        .mem_op_dest      (mem_op_dest),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk(input logic [15:0] alu, input logic we, input logic [15:0] wdata,
                                       input logic wb_en, input logic [2:0] dest, input logic mux);
        return {alu, we, wdata, wb_en, dest, mux};
    endfunction

    logic [15:0] alu_vals [3] = '{16'h0011, 16'h0022, 16'h0033};
    logic [2:0]  alu_dest [3] = '{3'd1, 3'd2, 3'd7};

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_req", dmem_req, 0);
        check("rst_out", pipeline_reg_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_terr", timeout_err, 0);
        tick();
        tick();
        rst = 1'b1;

        // Three back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            pipeline_reg_in = mk(alu_vals[i], 1'b0, 16'hAAAA, 1'b1, alu_dest[i], 1'b0);
            in_valid = 1'b1;
            tick();
            check($sformatf("alu%0d_valid", i), out_valid, 1);
            check($sformatf("alu%0d_word", i), pipeline_reg_out, {alu_vals[i], 16'h0000, 1'b1, alu_dest[i], 1'b0});
            check($sformatf("alu%0d_ready", i), in_ready, 1);
            check($sformatf("alu%0d_dest", i), mem_op_dest, alu_dest[i]);
        end
        in_valid = 1'b0;
        tick();
        check("bubble_valid", out_valid, 0);
        check("bubble_word", pipeline_reg_out, 0);

        // Load, ack sampled on the 4th edge after acceptance
        pipeline_reg_in = mk(16'h0040, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ld_req", dmem_req, 1);
        check("ld_we", dmem_we, 0);
        check("ld_addr", dmem_addr, 16'h0040);
        check("ld_ready0", in_ready, 0);
        check("ld_dest0", mem_op_dest, 3);
        check("ld_valid0", out_valid, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("ld_ready%0d", k), in_ready, 0);
            check($sformatf("ld_req%0d", k), dmem_req, 1);
            check($sformatf("ld_dest%0d", k), mem_op_dest, 3);
            check($sformatf("ld_valid%0d", k), out_valid, 0);
        end
        dmem_ack = 1'b1;
        dmem_rdata = 16'hBEEF;
        tick();
        dmem_ack = 1'b0;
        check("ld_done_valid", out_valid, 1);
        check("ld_done_word", pipeline_reg_out, {16'h0040, 16'hBEEF, 5'b1_011_1});
        check("ld_done_req", dmem_req, 0);
        check("ld_done_ready", in_ready, 1);
        check("ld_done_dest", mem_op_dest, 3);
        tick();
        check("ld_pulse", out_valid, 0);

        // Store with bit[0] also set, ack on first request cycle, rdata noise present
        pipeline_reg_in = mk(16'h0100, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("st_req", dmem_req, 1);
        check("st_we", dmem_we, 1);
        check("st_addr", dmem_addr, 16'h0100);
        check("st_wdata", dmem_wdata, 16'h1234);
        dmem_ack = 1'b1;
        dmem_rdata = 16'hFFFF;
        tick();
        dmem_ack = 1'b0;
        check("st_done_valid", out_valid, 1);
        check("st_done_word", pipeline_reg_out, {16'h0100, 16'h0000, 5'b0_000_1});
        check("st_done_dest", mem_op_dest, 0);
        tick();
        check("st_pulse", out_valid, 0);

        // Load with no ack: watchdog abort after 8 cycles
        pipeline_reg_in = mk(16'h0200, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("to_req%0d", k), dmem_req, 1);
        end
        check("to_terr_before", timeout_err, 0);
        tick();
        check("to_req_drop", dmem_req, 0);
        check("to_valid", out_valid, 1);
        check("to_word", pipeline_reg_out, {16'h0200, 16'h0000, 5'b0_101_1});
        check("to_terr", timeout_err, 1);
        check("to_dest", mem_op_dest, 0);
        check("to_ready", in_ready, 1);
        pipeline_reg_in = mk(16'h0055, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("to_sticky_alu", pipeline_reg_out, {16'h0055, 16'h0000, 5'b1_100_0});
        check("to_sticky", timeout_err, 1);
        tick();
        check("to_sticky2", timeout_err, 1);

        // Reset in the middle of an access, then a late ack
        pipeline_reg_in = mk(16'h0777, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_req", dmem_req, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", dmem_req, 0);
        check("mid_rst_addr", dmem_addr, 0);
        check("mid_rst_we", dmem_we, 0);
        check("mid_rst_wdata", dmem_wdata, 0);
        check("mid_rst_out", pipeline_reg_out, 0);
        check("mid_rst_terr", timeout_err, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_dest", mem_op_dest, 0);
        tick();
        rst = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 16'h5A5A;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_valid", out_valid, 0);
        check("late_ack_req", dmem_req, 0);
        check("late_ack_out", pipeline_reg_out, 0);

        // Ack on the 8th wait cycle wins over the watchdog
        pipeline_reg_in = mk(16'h0300, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
        end
        check("lim_req_held", dmem_req, 1);
        dmem_ack = 1'b1;
        dmem_rdata = 16'hCAFE;
        tick();
        dmem_ack = 1'b0;
        check("lim_valid", out_valid, 1);
        check("lim_word", pipeline_reg_out, {16'h0300, 16'hCAFE, 5'b1_110_1});
        check("lim_terr", timeout_err, 0);
        check("lim_req", dmem_req, 0);
        tick();
        check("lim_pulse", out_valid, 0);
        check("lim_terr2", timeout_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
